// File: rtl/bcd_entry_encoder_pkg.sv
// Shared types and helpers for the BCD entry encoder and its display-path peers.
//   state_t  : entry FSM states
//   BCD_MAX  : largest legal BCD digit
//   acc_w()  : bits needed to hold any value of up to max_digits decimal digits
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACCUM = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Equivalent to clog2(10**max_digits), written as a bounded loop so it
    // folds cleanly as a constant function.
    function automatic int acc_w(input int max_digits);
        int p;
        int w;
        p = 1;
        w = 0;
        for (int i = 0; i < max_digits; i++) begin
            p = p * 10;
        end
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < p) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_entry_encoder_if.sv
// Handshake/result bundle between the debounced digit front end (master)
// and the BCD entry encoder (slave).
//   digit/digit_valid : BCD digit strobe from the front end
//   commit/clear      : finish or abort the current entry
//   binary/bin_valid  : last committed value and its one-cycle update pulse
//   err/busy          : sticky error, entry-in-progress flag
//   digit_count       : digits accepted in the current entry
interface bcd_entry_encoder_if #(
    parameter int BIN_W = 4
);
    logic [3:0]       digit;
    logic             digit_valid;
    logic             commit;
    logic             clear;
    logic [BIN_W-1:0] binary;
    logic             bin_valid;
    logic             err;
    logic             busy;
    logic [1:0]       digit_count;

    modport master (
        output digit, digit_valid, commit, clear,
        input  binary, bin_valid, err, busy, digit_count
    );

    modport slave (
        input  digit, digit_valid, commit, clear,
        output binary, bin_valid, err, busy, digit_count
    );
endinterface

// File: rtl/bcd_entry_encoder_digit_check.sv
// Combinational BCD digit validator, also used by the display path.
//   digit_i  : 4-bit candidate digit
//   is_bcd_o : 1 when digit_i is 0..9
module bcd_digit_check
    import bcd_entry_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic       is_bcd_o
);
    assign is_bcd_o = (digit_i <= BCD_MAX);
endmodule

// File: rtl/bcd_entry_encoder.sv
// Accumulates decimal digits (MSD first) and, on commit, emits the binary
// value. Non-BCD digits, too many digits or an over-range value lock the
// block into a sticky error state until clear or rst.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of bcd_entry_encoder_if (digit/commit/clear in,
//         binary/bin_valid/err/busy/digit_count out)
module bcd_entry_encoder
    import bcd_entry_pkg::*;
#(
    parameter int BIN_W      = 4,
    parameter int MAX_DIGITS = 2,
    parameter int MAX_VAL    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_entry_encoder_if.slave   bus
);
    localparam int          ACC_W     = acc_w(MAX_DIGITS);
    localparam logic [31:0] MAX_VAL_U = 32'(MAX_VAL);
    localparam logic [1:0]  CNT_MAX   = 2'(MAX_DIGITS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             is_bcd;

    // Only reached with fewer than MAX_DIGITS digits accumulated, so the
    // result always fits ACC_W bits.
    function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] acc,
                                               input logic [3:0]       dig);
        return acc * ACC_W'(10) + ACC_W'(dig);
    endfunction

    bcd_digit_check u_digit_check (
        .digit_i  (bus.digit),
        .is_bcd_o (is_bcd)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        vld_d   = 1'b0;

        if (bus.clear) begin
            state_d = S_EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    // A commit with nothing entered is a no-op and also
                    // swallows a simultaneous digit.
                    if (!bus.commit && bus.digit_valid) begin
                        if (is_bcd) begin
                            acc_d   = ACC_W'(bus.digit);
                            cnt_d   = 2'd1;
                            state_d = S_ACCUM;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.commit) begin
                        if (32'(acc_q) > MAX_VAL_U) begin
                            state_d = S_ERR;
                        end else begin
                            bin_d   = acc_q[BIN_W-1:0];
                            vld_d   = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_EMPTY;
                        end
                    end else if (bus.digit_valid) begin
                        if (!is_bcd || cnt_q == CNT_MAX) begin
                            state_d = S_ERR;
                        end else begin
                            acc_d = mac10(acc_q, bus.digit);
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                S_ERR: begin
                    // Frozen until clear.
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end

        err_d  = (state_d == S_ERR);
        busy_d = (state_d == S_ACCUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.binary      = bin_q;
    assign bus.bin_valid   = vld_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.digit_count = cnt_q;

endmodule

// File: tb/tb_bcd_entry_encoder.sv
module tb_bcd_entry_encoder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bcd_entry_encoder_if #(.BIN_W(4)) bus ();

    bcd_entry_encoder #(
        .BIN_W      (4),
        .MAX_DIGITS (2),
        .MAX_VAL    (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Consume one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.digit       = 4'd0;
        bus.digit_valid = 1'b0;
        bus.commit      = 1'b0;
        bus.clear       = 1'b0;

        // 1: reset
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_binary", 32'(bus.binary), 0);
        chk("rst_vld",    32'(bus.bin_valid), 0);
        chk("rst_err",    32'(bus.err), 0);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_cnt",    32'(bus.digit_count), 0);

        // 2: 1,3 commit -> 13
        send_digit(4'd1);
        chk("t2_busy1", 32'(bus.busy), 1);
        chk("t2_cnt1",  32'(bus.digit_count), 1);
        send_digit(4'd3);
        chk("t2_cnt2",  32'(bus.digit_count), 2);
        do_commit();
        chk("t2_vld",    32'(bus.bin_valid), 1);
        chk("t2_binary", 32'(bus.binary), 13);
        chk("t2_cnt0",   32'(bus.digit_count), 0);
        chk("t2_busy0",  32'(bus.busy), 0);
        tick();
        chk("t2_vld_off", 32'(bus.bin_valid), 0);
        chk("t2_hold",    32'(bus.binary), 13);

        // 2b: boundary value 15 accepted, then back to 13
        send_digit(4'd1);
        send_digit(4'd5);
        do_commit();
        chk("t2b_vld", 32'(bus.bin_valid), 1);
        chk("t2b_bin", 32'(bus.binary), 15);
        send_digit(4'd1);
        send_digit(4'd3);
        do_commit();
        chk("t2b_bin13", 32'(bus.binary), 13);

        // 2c: clear mid-entry leaves binary alone, no pulse
        send_digit(4'd4);
        do_clear();
        chk("t2c_busy", 32'(bus.busy), 0);
        chk("t2c_cnt",  32'(bus.digit_count), 0);
        chk("t2c_vld",  32'(bus.bin_valid), 0);
        chk("t2c_bin",  32'(bus.binary), 13);

        // 3: 16 over range -> err
        send_digit(4'd1);
        send_digit(4'd6);
        do_commit();
        chk("t3_err",  32'(bus.err), 1);
        chk("t3_vld",  32'(bus.bin_valid), 0);
        chk("t3_bin",  32'(bus.binary), 13);
        chk("t3_busy", 32'(bus.busy), 0);
        do_clear();
        chk("t3_clr_err", 32'(bus.err), 0);

        // 4: non-BCD digit
        send_digit(4'hB);
        chk("t4_err", 32'(bus.err), 1);
        send_digit(4'd5);
        chk("t4_err_hold", 32'(bus.err), 1);
        chk("t4_cnt",      32'(bus.digit_count), 0);
        do_commit();
        chk("t4_vld", 32'(bus.bin_valid), 0);
        chk("t4_bin", 32'(bus.binary), 13);
        do_clear();
        chk("t4_clr_err", 32'(bus.err), 0);

        // 5: three digits -> err; then commit in S_EMPTY
        send_digit(4'd0);
        send_digit(4'd7);
        chk("t5_cnt2", 32'(bus.digit_count), 2);
        chk("t5_err0", 32'(bus.err), 0);
        send_digit(4'd2);
        chk("t5_err",    32'(bus.err), 1);
        chk("t5_cnt_fz", 32'(bus.digit_count), 2);
        do_clear();
        chk("t5_clr_cnt", 32'(bus.digit_count), 0);
        do_commit();
        chk("t5_empty_vld", 32'(bus.bin_valid), 0);
        chk("t5_empty_bin", 32'(bus.binary), 13);

        // 6: commit wins over same-cycle digit; then rst mid-entry
        send_digit(4'd9);
        bus.digit       = 4'd5;
        bus.digit_valid = 1'b1;
        bus.commit      = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        bus.commit      = 1'b0;
        chk("t6_vld",  32'(bus.bin_valid), 1);
        chk("t6_bin",  32'(bus.binary), 9);
        chk("t6_cnt",  32'(bus.digit_count), 0);
        tick();
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_vld0", 32'(bus.bin_valid), 0);
        send_digit(4'd1);
        chk("t6_busy1", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_bin",  32'(bus.binary), 0);
        chk("t6_rst_vld",  32'(bus.bin_valid), 0);
        chk("t6_rst_err",  32'(bus.err), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_cnt",  32'(bus.digit_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
